// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array result path
// (imported by sa_result_drain and the systolic-array wrapper).
package sa_pkg;

    localparam int SA_DATA_BITS  = 32;
    localparam int SA_DATAC_BITS = 128;
    localparam int SA_ROWS       = 4;
    localparam int SA_COLS       = 4;
    localparam int SA_WORDS      = 16;
    localparam int SA_IDX_BITS   = 4;
    localparam int SA_CNT_BITS   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_e;

    // Saturating increment for the 8-bit event counter.
    function automatic logic [SA_CNT_BITS-1:0] sat_inc8(input logic [SA_CNT_BITS-1:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/sa_result_drain.sv
// Drains a captured 4x4 result matrix as a 16-word row-major stream.
// Optional build macro SA_DRAIN_RELU_EN clamps negative words to zero at the output.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int DATA_BITS  = SA_DATA_BITS,
    parameter int DATAC_BITS = SA_DATAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sa_done,
    input  logic [DATAC_BITS-1:0] local_buffer_C0,
    input  logic [DATAC_BITS-1:0] local_buffer_C1,
    input  logic [DATAC_BITS-1:0] local_buffer_C2,
    input  logic [DATAC_BITS-1:0] local_buffer_C3,
    output logic [DATA_BITS-1:0]  m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            overrun_cnt
);

    drain_state_e           state_q, state_d;
    logic [SA_IDX_BITS-1:0] idx_q, idx_d;
    logic [DATAC_BITS-1:0]  cap_q [SA_ROWS];
    logic [DATAC_BITS-1:0]  cap_d [SA_ROWS];
    logic [DATA_BITS-1:0]   m_tdata_q, m_tdata_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic                   m_tlast_q, m_tlast_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [SA_CNT_BITS-1:0] overrun_cnt_q, overrun_cnt_d;

    logic                   hs_s;
    logic                   last_hs_s;
    logic [DATAC_BITS-1:0]  row_s;
    logic [DATA_BITS-1:0]   word_s;

    // Next-state: capture, word index advance and overrun detection.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cap_d         = cap_q;
        overrun_d     = 1'b0;
        overrun_cnt_d = overrun_cnt_q;
        hs_s          = (state_q == ST_SEND) && m_tready;
        last_hs_s     = hs_s && (idx_q == 4'(SA_WORDS - 1));

        case (state_q)
            ST_IDLE: begin
                if (sa_done) begin
                    cap_d[0] = local_buffer_C0;
                    cap_d[1] = local_buffer_C1;
                    cap_d[2] = local_buffer_C2;
                    cap_d[3] = local_buffer_C3;
                    idx_d    = 4'd0;
                    state_d  = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (last_hs_s) begin
                    // A new matrix landing on the final handshake is taken without a bubble.
                    idx_d = 4'd0;
                    if (sa_done) begin
                        cap_d[0] = local_buffer_C0;
                        cap_d[1] = local_buffer_C1;
                        cap_d[2] = local_buffer_C2;
                        cap_d[3] = local_buffer_C3;
                        state_d  = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (hs_s) begin
                        idx_d = idx_q + 4'd1;
                    end else begin
                        idx_d = idx_q;
                    end
                    if (sa_done) begin
                        overrun_d     = 1'b1;
                        overrun_cnt_d = sat_inc8(overrun_cnt_q);
                    end else begin
                        overrun_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // Output words are selected from next-state so every stream output is a flop.
    always_comb begin
        row_s  = cap_d[idx_d[3:2]];
        word_s = row_s[(SA_COLS - 1 - int'(idx_d[1:0])) * DATA_BITS +: DATA_BITS];
        if (state_d == ST_SEND) begin
            m_tvalid_d = 1'b1;
            busy_d     = 1'b1;
            m_tlast_d  = (idx_d == 4'(SA_WORDS - 1));
`ifdef SA_DRAIN_RELU_EN
            if (word_s[DATA_BITS-1]) begin
                m_tdata_d = '0;
            end else begin
                m_tdata_d = word_s;
            end
`else
            m_tdata_d = word_s;
`endif
        end else begin
            m_tvalid_d = 1'b0;
            busy_d     = 1'b0;
            m_tlast_d  = 1'b0;
            m_tdata_d  = '0;
        end
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= 4'd0;
            for (int r = 0; r < SA_ROWS; r++) begin
                cap_q[r] <= '0;
            end
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            for (int r = 0; r < SA_ROWS; r++) begin
                cap_q[r] <= cap_d[r];
            end
            m_tdata_q     <= m_tdata_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tlast_q     <= m_tlast_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign m_tdata     = m_tdata_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tlast     = m_tlast_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed self-checking bench for sa_result_drain; expected words are hand-computed
// from the row fill pattern (word i of a matrix = base + i + 1).
module tb_sa_result_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         sa_done;
    logic [127:0] c0, c1, c2, c3;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         busy;
    logic         overrun;
    logic [7:0]   overrun_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    sa_result_drain dut (
        .clk             (clk),
        .rst             (rst),
        .sa_done         (sa_done),
        .local_buffer_C0 (c0),
        .local_buffer_C1 (c1),
        .local_buffer_C2 (c2),
        .local_buffer_C3 (c3),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast),
        .busy            (busy),
        .overrun         (overrun),
        .overrun_cnt     (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row r, column c holds base + 4*r + c + 1.
    task automatic set_rows(input logic [31:0] base);
        c0 = {base + 32'd1,  base + 32'd2,  base + 32'd3,  base + 32'd4};
        c1 = {base + 32'd5,  base + 32'd6,  base + 32'd7,  base + 32'd8};
        c2 = {base + 32'd9,  base + 32'd10, base + 32'd11, base + 32'd12};
        c3 = {base + 32'd13, base + 32'd14, base + 32'd15, base + 32'd16};
    endtask

    task automatic start(input logic [31:0] base);
        set_rows(base);
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
    endtask

    initial begin
        int exp_i;
        int cyc;
        rst = 1'b1; sa_done = 1'b0; m_tready = 1'b0;
        set_rows(32'd0);
        tick(); tick();
        chk("rst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", m_tdata, 32'd0);
        chk("rst_cnt", {24'd0, overrun_cnt}, 32'd0);

        // sa_done during reset is ignored.
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        rst = 1'b0;
        tick();
        chk("done_in_rst", {31'd0, m_tvalid}, 32'd0);

        // Basic drain at full throughput.
        m_tready = 1'b1;
        start(32'd0);
        for (int k = 0; k < 16; k++) begin
            chk("basic_valid", {31'd0, m_tvalid}, 32'd1);
            chk("basic_data", m_tdata, 32'(k + 1));
            chk("basic_last", {31'd0, m_tlast}, {31'd0, (k == 15)});
            tick();
        end
        chk("basic_end_valid", {31'd0, m_tvalid}, 32'd0);
        chk("basic_end_busy", {31'd0, busy}, 32'd0);
        chk("basic_end_data", m_tdata, 32'd0);

        // Back-pressure with ready pattern 1,0,0 repeating.
        m_tready = 1'b0;
        start(32'h200);
        exp_i = 0;
        cyc = 0;
        while (exp_i < 16 && cyc < 100) begin
            m_tready = ((cyc % 3) == 0);
            chk("bp_valid", {31'd0, m_tvalid}, 32'd1);
            chk("bp_data", m_tdata, 32'h200 + 32'(exp_i + 1));
            chk("bp_last", {31'd0, m_tlast}, {31'd0, (exp_i == 15)});
            if (m_tready) exp_i++;
            tick();
            cyc++;
        end
        chk("bp_done", 32'(exp_i), 32'd16);
        chk("bp_end_valid", {31'd0, m_tvalid}, 32'd0);

        // Overrun: a second sa_done while idx=5 is dropped.
        m_tready = 1'b1;
        start(32'd0);
        for (int k = 0; k < 16; k++) begin
            chk("ovr_data", m_tdata, 32'(k + 1));
            chk("ovr_pulse", {31'd0, overrun}, {31'd0, (k == 6)});
            if (k == 5) begin
                set_rows(32'h500);
                sa_done = 1'b1;
            end else begin
                sa_done = 1'b0;
            end
            tick();
        end
        chk("ovr_cnt", {24'd0, overrun_cnt}, 32'd1);
        chk("ovr_end_valid", {31'd0, m_tvalid}, 32'd0);

        // Back-to-back: new matrix arrives with the idx=15 handshake.
        start(32'd0);
        for (int k = 0; k < 16; k++) begin
            chk("b2b_a_data", m_tdata, 32'(k + 1));
            if (k == 15) begin
                set_rows(32'h100);
                sa_done = 1'b1;
            end
            tick();
        end
        sa_done = 1'b0;
        chk("b2b_valid", {31'd0, m_tvalid}, 32'd1);
        chk("b2b_word0", m_tdata, 32'h101);
        chk("b2b_ovr", {31'd0, overrun}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            chk("b2b_b_data", m_tdata, 32'h100 + 32'(k + 1));
            chk("b2b_b_last", {31'd0, m_tlast}, {31'd0, (k == 15)});
            tick();
        end
        chk("b2b_cnt", {24'd0, overrun_cnt}, 32'd1);
        chk("b2b_end_busy", {31'd0, busy}, 32'd0);

        // Reset mid-stream at idx=7, then restart.
        start(32'd0);
        for (int k = 0; k < 7; k++) tick();
        chk("mid_idx7", m_tdata, 32'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_valid", {31'd0, m_tvalid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_last", {31'd0, m_tlast}, 32'd0);
        chk("mid_cnt", {24'd0, overrun_cnt}, 32'd0);
        start(32'h300);
        chk("mid_restart", m_tdata, 32'h301);
        for (int k = 0; k < 16; k++) tick();
        chk("mid_end_valid", {31'd0, m_tvalid}, 32'd0);

        // ReLU clamp on a negative word 0.
        set_rows(32'd0);
        c0[127:96] = 32'hFFFF_FFF6;
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
`ifdef SA_DRAIN_RELU_EN
        chk("relu_word0", m_tdata, 32'h0000_0000);
`else
        chk("relu_word0", m_tdata, 32'hFFFF_FFF6);
`endif
        tick();
        chk("relu_word1", m_tdata, 32'd2);
        for (int k = 0; k < 15; k++) tick();
        chk("relu_end_valid", {31'd0, m_tvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sa_result_drain.md
SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, meaning the width of one result word and of the output stream.
REQ-002 SHALL have parameter DATAC_BITS, default 128, meaning the width of one result row (4 x DATA_BITS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sa_done, input, 1 bit: one-cycle pulse from the systolic array; the C rows are valid in that cycle.
REQ-006 SHALL have ports local_buffer_C0..C3, input, DATAC_BITS each: result rows 0..3; column 0 sits in bits [127:96] and column 3 in bits [31:0].
REQ-007 SHALL have port m_tdata, output, DATA_BITS: the current result word.
REQ-008 SHALL have port m_tvalid, output, 1 bit: m_tdata is valid.
REQ-009 SHALL have port m_tready, input, 1 bit: downstream accepts the word.
REQ-010 SHALL have port m_tlast, output, 1 bit: marks word 15 of the matrix.
REQ-011 SHALL have port busy, output, 1 bit: a matrix is held or being sent.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when an sa_done is dropped.
REQ-013 SHALL have port overrun_cnt, output, 8 bits: saturating count of dropped sa_done pulses.

Function
REQ-014 SHALL implement the states IDLE and SEND.
REQ-015 SHALL, in IDLE on sa_done=1, capture all four C rows into an internal 4x128 register, clear the word index to 0 and enter SEND.
REQ-016 SHALL assert m_tvalid in the cycle after the capture (1-cycle latency).
REQ-017 SHALL, in SEND, drive m_tvalid=1, m_tdata=word[idx] and busy=1.
REQ-018 SHALL index words row-major: idx=4*row+col, with word 0 = C0[127:96] and word 15 = C3[31:0].
REQ-019 SHALL advance idx only on a handshake (m_tvalid & m_tready).
REQ-020 SHALL hold m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-021 SHALL assert m_tlast only when idx=15.
REQ-022 SHALL, on the handshake at idx=15 without sa_done, return to IDLE, so that m_tvalid=0 the next cycle.
REQ-023 SHALL, when sa_done=1 in the same cycle as the idx=15 handshake, capture the new rows, set idx=0 and stay in SEND, with no bubble and no overrun.
REQ-024 SHALL, on sa_done=1 in SEND at any other time, ignore the new data, pulse overrun for 1 cycle and increment overrun_cnt, saturating at 255.
REQ-025 SHALL drive m_tvalid=0 and busy=0 in IDLE, and SHALL then drive m_tdata to 0.
REQ-026 SHALL ignore m_tready in IDLE.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, enter IDLE, set idx=0, clear the capture register, and set m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, overrun=0 and overrun_cnt=0.
REQ-028 SHALL, on rst asserted mid-SEND, discard the remaining words with no m_tlast emitted.
REQ-029 SHALL ignore sa_done in any cycle where rst=1.

Configuration
REQ-030 SHALL, when macro SA_DRAIN_RELU_EN is defined, replace each output word whose bit 31 is 1 (negative signed) with 0 at m_tdata; the capture register keeps the raw value.
REQ-031 SHALL, when SA_DRAIN_RELU_EN is undefined, present words unmodified; the handshake and timing SHALL be identical in both builds.

Structure
REQ-032 SHALL take DATA_BITS, DATAC_BITS, SA_ROWS=4, SA_COLS=4, SA_WORDS=16 and the state encoding (IDLE/SEND) from a shared package sa_pkg, which sa_result_drain and the systolic-array wrapper both import.
REQ-033 SHALL contain no sub-module; the 16:1 word select and the ReLU clamp SHALL be inline logic.

Verification
REQ-034 SHALL cover a basic drain: C0=0x00000001_00000002_00000003_00000004 and C1..C3 filled incrementally, m_tready=1, sa_done pulsed once -> 16 words 1,2,3,...,16 on consecutive cycles starting 1 cycle after sa_done; m_tlast=1 only with word 16; busy falls after it.
REQ-035 SHALL cover back-pressure: m_tready toggled 1,0,0,1,... -> no word lost or duplicated, and m_tdata/m_tlast held constant during every stall.
REQ-036 SHALL cover overrun: a second sa_done at idx=5 -> overrun pulses once, overrun_cnt=1, and the output still equals the first matrix.
REQ-037 SHALL cover back-to-back capture: sa_done coincident with the idx=15 handshake -> word 0 of the new matrix appears the next cycle, and overrun stays 0.
REQ-038 SHALL cover reset mid-stream: rst=1 at idx=7 -> the next cycle shows m_tvalid=0, busy=0 and overrun_cnt=0, and a fresh sa_done restarts at word 0.
REQ-039 SHALL cover ReLU: with SA_DRAIN_RELU_EN defined and C0[127:96]=0xFFFFFFF6 (-10) -> word 0 reads 0x00000000; without the macro -> word 0 reads 0xFFFFFFF6.
